// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display stage: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the BCD converter state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Nibble to active-low segment pattern; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_bin2bcd.sv
// Sequential double-dabble converter: one bit per clock, WIDTH shift cycles,
// then the finished digits are published to bcd in a single update.
module bin2bcd
  import seg_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  conv_state_t           state_reg;
  logic [WIDTH-1:0]      bin_reg;
  logic [4*DIGITS-1:0]   scratch_reg;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  busy_reg;

  // Add-3 correction applied to every scratch digit before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                              4'(scratch_reg[4*gi +: 4] + 4'd3) :
                              scratch_reg[4*gi +: 4];
    end
  endgenerate

  // Converter FSM: capture on start, shift WIDTH times, then publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg     <= bin;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= {adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
          bin_reg     <= {bin_reg[WIDTH-2:0], 1'b0};
          cnt_reg     <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH-1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          bcd_reg   <= scratch_reg;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/seg_display.sv
// Display stage: detects a new input value, converts it to BCD and scans
// the digits onto a multiplexed active-low 7-segment display.
module seg_display
  import seg_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int DIGITS  = 3,
  parameter int REFRESH = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      val,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [WIDTH-1:0]   cur_reg;
  logic               start;
  logic [RW-1:0]      refresh_reg;
  logic [IW-1:0]      idx_reg;
  logic [DIGITS-1:0]  an_reg;
  logic [6:0]         seg_reg;
  logic [DIGITS-1:0]  blank;
  logic [3:0]         nib;

  // The converter only reports idle when it is back in IDLE, so a new
  // value is accepted exactly when the FSM can take it.
  assign start = (val != cur_reg) && !busy;

  // Latch the value being converted so later changes are detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg <= '0;
    end else if (start) begin
      cur_reg <= val;
    end
  end

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (val),
    .bcd   (bcd),
    .busy  (busy)
  );

  // A digit is blanked when it and every more significant digit are zero;
  // the least significant digit always shows.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else if (gi == DIGITS-1) begin : g_msd
        assign blank[gi] = (bcd[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign blank[gi] = (bcd[4*gi +: 4] == 4'd0) && blank[gi+1];
      end
    end
  endgenerate

  assign nib = bcd[4*idx_reg +: 4];

  // Refresh timer and digit scan; outputs registered from the current slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_reg <= '0;
      idx_reg     <= '0;
      an_reg      <= '1;
      seg_reg     <= SEG_OFF;
    end else begin
      if (refresh_reg == RW'(REFRESH-1)) begin
        refresh_reg <= '0;
        idx_reg     <= (idx_reg == IW'(DIGITS-1)) ? '0 : idx_reg + 1'b1;
      end else begin
        refresh_reg <= refresh_reg + 1'b1;
      end
      an_reg  <= ~(DIGITS'(1) << idx_reg);
      seg_reg <= blank[idx_reg] ? SEG_OFF : seg_decode(nib);
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with a short refresh period.
module tb_seg_display;

  localparam int WIDTH   = 7;
  localparam int DIGITS  = 3;
  localparam int REFRESH = 4;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     val;
  logic [DIGITS-1:0]    an;
  logic [6:0]           seg;
  logic                 dp;
  logic [4*DIGITS-1:0]  bcd;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .REFRESH (REFRESH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .val  (val),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .bcd  (bcd),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts negedges with busy high, starting at the next negedge.
  task automatic wait_busy(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_conv(input logic [WIDTH-1:0] v, output int cyc);
    val = v;
    wait_busy(cyc);
  endtask

  // Waits for the slot of digit d and returns the segment pattern shown.
  task automatic get_seg(input int d, output logic [6:0] s, output bit ok);
    logic [DIGITS-1:0] target;
    target = ~(DIGITS'(1) << d);
    ok = 1'b0;
    s  = 7'h00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4*REFRESH*DIGITS; k++) begin
      if (an === target) begin
        ok = 1'b1;
        s  = seg;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b0;
    val = 7'd5;
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 3'b111) begin n_fail++; $display("FAIL reset_an: got %b want %b", an, 3'b111); end
    n_checks++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want %h", seg, 7'h7F); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    n_checks++;
    if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h want %h", bcd, 12'h000); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    wait_busy(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL reset_release_busy_cycles: got %0d want 8", cyc); end
    n_checks++;
    if (bcd !== 12'h005) begin n_fail++; $display("FAIL reset_release_bcd: got %h want %h", bcd, 12'h005); end
    $display("test_reset: val=5 busy_cycles=%0d bcd=%h", cyc, bcd);
  endtask

  task automatic test_convert_13;
    int cyc;
    bit ok;
    logic [6:0] s;
    logic [6:0] exp_seg [3];
    exp_seg[0] = 7'h30; exp_seg[1] = 7'h79; exp_seg[2] = 7'h7F;
    run_conv(7'd13, cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL conv13_busy_cycles: got %0d want 8", cyc); end
    n_checks++;
    if (bcd !== 12'h013) begin n_fail++; $display("FAIL conv13_bcd: got %h want %h", bcd, 12'h013); end
    for (int d = 0; d < DIGITS; d++) begin
      get_seg(d, s, ok);
      n_checks++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++;
        $display("FAIL conv13_seg_digit%0d: got %h (slot_found=%0d) want %h", d, s, ok, exp_seg[d]);
      end
    end
    $display("test_convert_13: busy_cycles=%0d bcd=%h", cyc, bcd);
  endtask

  task automatic test_extremes;
    int cyc;
    bit ok;
    logic [6:0] s;
    logic [6:0] exp_seg [3];
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F;
    run_conv(7'd127, cyc);
    n_checks++;
    if (cyc !== 8 || bcd !== 12'h127) begin
      n_fail++;
      $display("FAIL conv127: got bcd=%h cycles=%0d want bcd=%h cycles=8", bcd, cyc, 12'h127);
    end
    $display("test_extremes: val=127 bcd=%h", bcd);
    run_conv(7'd0, cyc);
    n_checks++;
    if (cyc !== 8 || bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL conv0: got bcd=%h cycles=%0d want bcd=%h cycles=8", bcd, cyc, 12'h000);
    end
    for (int d = 0; d < DIGITS; d++) begin
      get_seg(d, s, ok);
      n_checks++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++;
        $display("FAIL zero_seg_digit%0d: got %h (slot_found=%0d) want %h", d, s, ok, exp_seg[d]);
      end
    end
    $display("test_extremes: val=0 bcd=%h", bcd);
  endtask

  task automatic test_back_to_back;
    int cyc;
    val = 7'd50;
    cyc = 0;
    @(negedge clk);
    if (busy) cyc = 1;
    repeat (3) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    val = 7'd99;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL b2b_first_busy_cycles: got %0d want 8", cyc); end
    n_checks++;
    if (bcd !== 12'h050) begin n_fail++; $display("FAIL b2b_first_bcd: got %h want %h", bcd, 12'h050); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got busy=%b want 0", busy); end
    wait_busy(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL b2b_second_busy_cycles: got %0d want 8", cyc); end
    n_checks++;
    if (bcd !== 12'h099) begin n_fail++; $display("FAIL b2b_second_bcd: got %h want %h", bcd, 12'h099); end
    $display("test_back_to_back: 50 then 99 -> bcd=%h", bcd);
  endtask

  task automatic test_no_change;
    int hits;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) hits++;
    end
    n_checks++;
    if (hits !== 0) begin n_fail++; $display("FAIL no_change_busy: got %0d busy cycles want 0", hits); end
    n_checks++;
    if (bcd !== 12'h099) begin n_fail++; $display("FAIL no_change_bcd: got %h want %h", bcd, 12'h099); end
    $display("test_no_change: busy_cycles=%0d bcd=%h", hits, bcd);
  endtask

  task automatic test_scan;
    logic [DIGITS-1:0] prev;
    logic [DIGITS-1:0] exp_an [3];
    logic [6:0]        exp_seg [3];
    bit found;
    int slot;
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
    exp_seg[0] = 7'h10; exp_seg[1] = 7'h10; exp_seg[2] = 7'h7F;
    found = 1'b0;
    prev = an;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an === 3'b110 && prev !== 3'b110) begin
        found = 1'b1;
        break;
      end
      prev = an;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL scan_align: got no entry into an=110 want entry within 40 cycles"); end
    for (int s = 0; s < 16; s++) begin
      slot = (s / REFRESH) % DIGITS;
      n_checks++;
      if (an !== exp_an[slot] || seg !== exp_seg[slot]) begin
        n_fail++;
        $display("FAIL scan_cycle%0d: got an=%b seg=%h want an=%b seg=%h", s, an, seg, exp_an[slot], exp_seg[slot]);
      end
      @(negedge clk);
    end
    $display("test_scan: 16 cycles scanned for bcd=%h", bcd);
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    logic [6:0] s;
    logic [6:0] exp_seg [3];
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h40; exp_seg[2] = 7'h79;
    val = 7'd100;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_precond_busy: got %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (an !== 3'b111 || seg !== 7'h7F || bcd !== 12'h000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got an=%b seg=%h bcd=%h busy=%b want an=111 seg=7f bcd=000 busy=0",
               an, seg, bcd, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_busy(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL midreset_rerun_cycles: got %0d want 8", cyc); end
    n_checks++;
    if (bcd !== 12'h100) begin n_fail++; $display("FAIL midreset_rerun_bcd: got %h want %h", bcd, 12'h100); end
    for (int d = 0; d < DIGITS; d++) begin
      get_seg(d, s, ok);
      n_checks++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++;
        $display("FAIL val100_seg_digit%0d: got %h (slot_found=%0d) want %h", d, s, ok, exp_seg[d]);
      end
    end
    $display("test_reset_mid: rerun bcd=%h", bcd);
  endtask

  initial begin
    rst = 1'b0;
    val = '0;
    test_reset();
    test_convert_13();
    test_extremes();
    test_back_to_back();
    test_no_change();
    test_scan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
